fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter for the async FIFO; lives entirely in the write clock domain.
- Shares the single FIFO write port (wr_en/data_in) among N_REQ producers.
- Grants one producer at a time for a bounded burst, stalls on FIFO full without ever writing while full.
- Exposes a running write-beat count for status/coverage.

---
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among N_REQ producers.
// Bounded bursts per grant, one bubble between grants, never writes while full.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int Data_Width = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        wr_clk,
    input  logic                        wr_rstn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*Data_Width-1:0] req_data,
    output logic [N_REQ-1:0]            req_ack,
    output logic [N_REQ-1:0]            grant,
    input  logic                        full,
    output logic                        wr_en,
    output logic [Data_Width-1:0]       data_in,
    output logic                        busy,
    output logic [CNT_W-1:0]            wr_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    logic                                 wr_ok;
    logic                                 owner_valid;
    logic [IDX_W-1:0]                     own_idx;
    logic                                 win_found;
    logic [IDX_W-1:0]                     win_idx;
    logic [IDX_W-1:0]                     cand_idx;
    int                                   cand;
    logic [N_REQ-1:0][Data_Width-1:0]     lane_data;

    // Writes are only possible from GRANT and only when the FIFO has room.
    assign wr_ok = (state_q == S_GRANT) & ~full;

    // Per-lane ack and zero-masked data; only the owner lane can ever fire.
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign req_ack[i]   = grant_q[i] & req_valid[i] & wr_ok;
        assign lane_data[i] = req_ack[i] ? req_data[i*Data_Width +: Data_Width]
                                         : '0;
    end

    assign wr_en       = |req_ack;
    assign owner_valid = |(grant_q & req_valid);

    always_comb begin
        data_in = '0;
        for (int k = 0; k < N_REQ; k++) begin
            data_in = data_in | lane_data[k];
        end
    end

    always_comb begin
        own_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                own_idx = IDX_W'(k);
            end
        end
    end

    // First requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wr_count_d  = wr_en ? wr_count_q + 1'b1 : wr_count_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d          = S_GRANT;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    burst_cnt_d      = '0;
                end
            end
            S_GRANT: begin
                // A stalled owner (full) keeps the grant; dropping valid ends the burst.
                if (!owner_valid || (wr_en && burst_cnt_q == LAST_BEAT)) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (own_idx == LAST_IDX) ? '0 : own_idx + 1'b1;
                end else if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == S_GRANT);
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producers react to req_ack, expectations are hand-timed.
// wr_count is built 8 bits wide here so the wrap point is reachable in a short run.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 8;

    logic              wr_clk = 1'b0;
    logic              wr_rstn = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      grant;
    logic              full = 1'b0;
    logic              wr_en;
    logic [DW-1:0]     data_in;
    logic              busy;
    logic [CW-1:0]     wr_count;

    int checks = 0;
    int errors = 0;
    int left[N];
    int nbeat[N];

    logic [N-1:0]  s_grant, s_ack;
    logic          s_wr_en, s_busy;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .Data_Width(DW), .MAX_BURST(4), .CNT_W(CW)) dut (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .grant(grant), .full(full), .wr_en(wr_en),
        .data_in(data_in), .busy(busy), .wr_count(wr_count)
    );

    always #5 wr_clk = ~wr_clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input int i, input int n);
        return DW'((i << 4) | ((n + 1) & 15));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input int n);
        left[i] = n;
        req_valid[i] = (n > 0);
        req_data[i*DW +: DW] = mk(i, nbeat[i]);
    endtask

    // One clock: sample at negedge, then advance producers on accepted beats.
    task automatic cyc();
        @(negedge wr_clk);
        s_grant = grant; s_ack = req_ack; s_wr_en = wr_en;
        s_data = data_in; s_busy = busy; s_cnt = wr_count;
        chk("never_wr_full", {31'd0, wr_en & full}, 32'd0);
        chk("ack_onehot0", {31'd0, $onehot0(req_ack)}, 32'd1);
        chk("ack_owner_only", req_ack & ~grant, 32'd0);
        chk("data_zero_no_wr", wr_en ? '0 : data_in, 32'd0);
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_ack[i]) begin
                nbeat[i]++;
                left[i]--;
                if (left[i] == 0) req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = mk(i, nbeat[i]);
            end
        end
    endtask

    task automatic exp_cyc(input string tag, input logic [N-1:0] g, input logic we,
                           input logic [DW-1:0] d);
        cyc();
        chk({tag, "_grant"}, s_grant, g);
        chk({tag, "_wr_en"}, s_wr_en, we);
        chk({tag, "_data"}, s_data, we ? d : '0);
        chk({tag, "_busy"}, s_busy, |g);
        chk({tag, "_ack"}, s_ack, we ? g : '0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        full = 1'b0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            nbeat[i] = 0;
            req_data[i*DW +: DW] = mk(i, 0);
        end
        wr_rstn = 1'b0;
        repeat (2) @(posedge wr_clk);
        #1;
        wr_rstn = 1'b1;
    endtask

    initial begin
        // Single requester 2, three beats, then release by dropped valid.
        do_reset();
        exp_cyc("reset_idle", 4'b0000, 1'b0, 8'h00);
        chk("reset_count", s_cnt, 32'd0);
        set_req(2, 3);
        exp_cyc("t1_req", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t1_b0", 4'b0100, 1'b1, 8'h21);
        exp_cyc("t1_b1", 4'b0100, 1'b1, 8'h22);
        exp_cyc("t1_b2", 4'b0100, 1'b1, 8'h23);
        exp_cyc("t1_rel", 4'b0100, 1'b0, 8'h00);
        exp_cyc("t1_idle", 4'b0000, 1'b0, 8'h00);
        chk("t1_count", s_cnt, 32'd3);
        // rr_ptr is now 3: with 0 and 3 both waiting, 3 wins first.
        set_req(0, 1);
        set_req(3, 1);
        exp_cyc("t1r_idle", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t1r_g3", 4'b1000, 1'b1, 8'h31);
        exp_cyc("t1r_rel3", 4'b1000, 1'b0, 8'h00);
        exp_cyc("t1r_bub", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t1r_g0", 4'b0001, 1'b1, 8'h01);
        exp_cyc("t1r_rel0", 4'b0001, 1'b0, 8'h00);
        exp_cyc("t1r_end", 4'b0000, 1'b0, 8'h00);
        chk("t1r_count", s_cnt, 32'd5);

        // All four continuously valid: 0,1,2,3,0 with 4 beats and a bubble each.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 8);
        for (int g = 0; g < N; g++) begin
            exp_cyc("t2_bub", 4'b0000, 1'b0, 8'h00);
            for (int b = 0; b < 4; b++) exp_cyc("t2_beat", 4'(1 << g), 1'b1, mk(g, b));
        end
        exp_cyc("t2_bub4", 4'b0000, 1'b0, 8'h00);
        chk("t2_count16", s_cnt, 32'd16);
        for (int b = 0; b < 4; b++) exp_cyc("t2_again0", 4'b0001, 1'b1, mk(0, 4 + b));

        // Requester 1 stalled by full for 5 cycles after 2 beats.
        do_reset();
        set_req(1, 4);
        exp_cyc("t3_req", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t3_b0", 4'b0010, 1'b1, 8'h11);
        exp_cyc("t3_b1", 4'b0010, 1'b1, 8'h12);
        full = 1'b1;
        repeat (5) exp_cyc("t3_stall", 4'b0010, 1'b0, 8'h00);
        full = 1'b0;
        exp_cyc("t3_b2", 4'b0010, 1'b1, 8'h13);
        exp_cyc("t3_b3", 4'b0010, 1'b1, 8'h14);
        exp_cyc("t3_rel", 4'b0000, 1'b0, 8'h00);
        chk("t3_count", s_cnt, 32'd4);
        // Valid and full together: stall, then the beat lands once full clears.
        set_req(3, 1);
        full = 1'b1;
        exp_cyc("t3s_idle", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t3s_stall", 4'b1000, 1'b0, 8'h00);
        full = 1'b0;
        exp_cyc("t3s_beat", 4'b1000, 1'b1, 8'h31);
        exp_cyc("t3s_rel", 4'b1000, 1'b0, 8'h00);
        exp_cyc("t3s_end", 4'b0000, 1'b0, 8'h00);
        chk("t3s_count", s_cnt, 32'd5);

        // Requester 0 drops after 1 beat; search from 1 skips idle 1,2 to reach 3.
        do_reset();
        set_req(0, 1);
        set_req(3, 4);
        exp_cyc("t4_req", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t4_g0", 4'b0001, 1'b1, 8'h01);
        exp_cyc("t4_rel0", 4'b0001, 1'b0, 8'h00);
        exp_cyc("t4_bub", 4'b0000, 1'b0, 8'h00);
        for (int b = 0; b < 4; b++) exp_cyc("t4_g3", 4'b1000, 1'b1, mk(3, b));
        exp_cyc("t4_end", 4'b0000, 1'b0, 8'h00);
        chk("t4_count", s_cnt, 32'd5);

        // Asynchronous reset mid-burst, then arbitration restarts from requester 0.
        do_reset();
        set_req(0, 1);
        set_req(2, 4);
        exp_cyc("t5_req", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t5_g0", 4'b0001, 1'b1, 8'h01);
        exp_cyc("t5_rel0", 4'b0001, 1'b0, 8'h00);
        exp_cyc("t5_bub", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t5_b0", 4'b0100, 1'b1, 8'h21);
        exp_cyc("t5_b1", 4'b0100, 1'b1, 8'h22);
        wr_rstn = 1'b0;
        #1;
        chk("t5_rst_grant", grant, 32'd0);
        chk("t5_rst_busy", busy, 32'd0);
        chk("t5_rst_wr_en", wr_en, 32'd0);
        chk("t5_rst_count", wr_count, 32'd0);
        chk("t5_rst_ack", req_ack, 32'd0);
        chk("t5_rst_data", data_in, 32'd0);
        set_req(0, 1);
        set_req(3, 1);
        @(posedge wr_clk);
        #1;
        wr_rstn = 1'b1;
        exp_cyc("t5_idle", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t5_restart0", 4'b0001, 1'b1, mk(0, 1));

        // 255 beats with periodic full, then one more beat wraps wr_count to 0.
        do_reset();
        set_req(0, 255);
        for (int c = 0; c < 600 && left[0] != 0; c++) begin
            full = ((c % 7) == 3);
            cyc();
        end
        full = 1'b0;
        chk("t6_done_in_budget", left[0], 32'd0);
        cyc();
        cyc();
        chk("t6_count255", s_cnt, 32'd255);
        set_req(0, 1);
        exp_cyc("t6_req", 4'b0000, 1'b0, 8'h00);
        exp_cyc("t6_beat", 4'b0001, 1'b1, mk(0, 255));
        exp_cyc("t6_rel", 4'b0001, 1'b0, 8'h00);
        exp_cyc("t6_end", 4'b0000, 1'b0, 8'h00);
        chk("t6_wrap0", s_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
